// File: rtl/counter_bus_master.sv
// Bus initiator for the counter peripheral: one select/ack transaction at a time from a
// valid/ready command port, with timeout errors and automatic status reads on interrupt edges.
module counter_bus_master #(
  parameter int         TIMEOUT  = 15,
  parameter logic [3:0] IRQ_ADDR = 4'h0,
  parameter bit         IRQ_EN   = 1'b1
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_wr,
  input  logic [3:0]  i_cmd_addr,
  input  logic [15:0] i_cmd_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_rsp_irq,
  output logic        o_bus_select,
  output logic        o_bus_wr,
  output logic [3:0]  o_reg_addr,
  output logic [15:0] o_bus_data,
  input  logic [15:0] i_bus_data,
  input  logic        i_bus_ack,
  input  logic        i_int_flg
);

  localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [3:0]        addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              is_irq_q, is_irq_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_irq_q, rsp_irq_d;
  logic              int_q;
  logic              irq_pend_q, irq_pend_d;
  logic              int_rise;
  logic              irq_clr;

  assign int_rise = IRQ_EN && i_int_flg && !int_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_irq_d   = is_irq_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_irq_d  = rsp_irq_q;
    irq_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A pending interrupt read always goes ahead of a waiting host command.
        if (irq_pend_q) begin
          state_d  = S_ISSUE;
          wr_d     = 1'b0;
          addr_d   = IRQ_ADDR;
          wdata_d  = 16'h0;
          is_irq_d = 1'b1;
          cnt_d    = '0;
          irq_clr  = 1'b1;
        end else if (i_cmd_valid && o_cmd_ready) begin
          state_d  = S_ISSUE;
          wr_d     = i_cmd_wr;
          addr_d   = i_cmd_addr;
          wdata_d  = i_cmd_wr ? i_cmd_data : 16'h0;
          is_irq_d = 1'b0;
          cnt_d    = '0;
        end
      end

      S_ISSUE: begin
        // Ack is checked first so an ack on the timeout edge still completes cleanly.
        if (i_bus_ack) begin
          state_d    = S_RESP;
          rsp_data_d = wr_q ? 16'h0 : i_bus_data;
          rsp_err_d  = 1'b0;
          rsp_irq_d  = is_irq_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_RESP;
          rsp_data_d = 16'h0;
          rsp_err_d  = 1'b1;
          rsp_irq_d  = is_irq_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (i_rsp_ready) begin
          state_d    = S_IDLE;
          rsp_data_d = 16'h0;
          rsp_err_d  = 1'b0;
          rsp_irq_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A new edge on the same cycle the pending read is launched re-arms it.
    irq_pend_d = IRQ_EN && (int_rise || (irq_pend_q && !irq_clr));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= 4'h0;
      wdata_q    <= 16'h0;
      is_irq_q   <= 1'b0;
      rsp_data_q <= 16'h0;
      rsp_err_q  <= 1'b0;
      rsp_irq_q  <= 1'b0;
      int_q      <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_irq_q   <= is_irq_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_irq_q  <= rsp_irq_d;
      int_q      <= i_int_flg;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign o_cmd_ready  = (state_q == S_IDLE) && !irq_pend_q && !i_sysrst;
  assign o_bus_select = (state_q == S_ISSUE);
  assign o_bus_wr     = (state_q == S_ISSUE) && wr_q;
  assign o_reg_addr   = addr_q;
  assign o_bus_data   = wdata_q;
  assign o_rsp_valid  = (state_q == S_RESP);
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_rsp_irq    = rsp_irq_q;

endmodule
